stream_wrr_scheduler: RTL



---
 rtl/stream_sched_pkg.sv | 48 ++++
 rtl/rr_select.sv | 41 ++++
 rtl/stream_wrr_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stream_sched_pkg.sv
// -----------------------------------------------------------------------------
// stream_sched_pkg
// Shared types and helpers for the stream schedulers and arbiters.
//   sched_state_e  : scheduler FSM states (IDLE, SERVE, FLUSH)
//   rr_result_t    : {found, idx} result of a rotating-priority search
//   rr_find_first  : first set request bit at or after ptr, with wrap at num
// -----------------------------------------------------------------------------
package stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    FLUSH
  } sched_state_e;

  localparam int MaxReq      = 16;
  localparam int MaxIdxWidth = 4;

  typedef struct packed {
    logic                   found;
    logic [MaxIdxWidth-1:0] idx;
  } rr_result_t;

  // Scan req[ptr], req[ptr+1], ... req[num-1], req[0], ... and return the
  // first set bit. The running index stays below 2*num, so a single
  // conditional subtract wraps it without a real modulo operator.
  function automatic rr_result_t rr_find_first(
    input logic [MaxReq-1:0]      req,
    input logic [MaxIdxWidth-1:0] ptr,
    input logic [MaxIdxWidth:0]   num
  );
    rr_result_t res;
    logic [MaxIdxWidth+1:0] k;
    res = '0;
    for (int off = 0; off < MaxReq; off++) begin
      k = {2'b00, ptr} + 6'(off);
      if (k >= {1'b0, num}) begin
        k = k - {1'b0, num};
      end
      if (!res.found && (off < int'(num)) && req[k[MaxIdxWidth-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[MaxIdxWidth-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational rotate-and-find-first over NumReq request bits.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   found_o : at least one request bit is set
//   idx_o   : index of the selected request (valid when found_o)
// -----------------------------------------------------------------------------
module rr_select
  import stream_sched_pkg::*;
#(
  parameter  int NumReq   = 4,
  localparam int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                found_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [MaxReq-1:0]      req_pad;
  logic [MaxIdxWidth-1:0] ptr_pad;
  rr_result_t             res;
  logic                   unused_idx_bits;

  // Widen to the fixed search width; the unused upper lanes stay zero.
  always_comb begin
    req_pad                 = '0;
    req_pad[NumReq-1:0]     = req_i;
    ptr_pad                 = '0;
    ptr_pad[IdxWidth-1:0]   = ptr_i;
  end

  assign res     = rr_find_first(req_pad, ptr_pad, 5'(NumReq));
  assign found_o = res.found;
  assign idx_o   = res.idx[IdxWidth-1:0];

  // The upper index bits are always zero for NumReq < 16.
  assign unused_idx_bits = ^res.idx;

endmodule

// File: rtl/stream_wrr_scheduler.sv
// -----------------------------------------------------------------------------
// stream_wrr_scheduler
// Weighted round-robin scheduler sharing one downstream ready/valid port
// among NumReq requesters, with per-requester burst quotas and a
// synchronized flush sequence.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : flush request (highest priority)
//   weight_i     : burst quota per requester, slice k is requester k
//   data_i       : requester payloads
//   valid_i      : requester valids
//   ready_o      : requester readies (at most one bit set)
//   data_o       : granted payload
//   valid_o      : downstream valid
//   ready_i      : downstream ready
//   idx_o        : current or just-selected requester index
//   flush_o      : one-cycle flush pulse, one cycle after flush_i
//   busy_o       : grant held or flush in progress
// -----------------------------------------------------------------------------
module stream_wrr_scheduler
  import stream_sched_pkg::*;
#(
  parameter  int  NumReq      = 4,
  parameter  int  WeightWidth = 4,
  parameter  type type_t      = logic,
  localparam int  IdxWidth    = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumReq*WeightWidth-1:0] weight_i,
  input  type_t                         data_i [NumReq],
  input  logic [NumReq-1:0]             valid_i,
  output logic [NumReq-1:0]             ready_o,
  output type_t                         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [IdxWidth-1:0]           idx_o,
  output logic                          flush_o,
  output logic                          busy_o
);

  sched_state_e           state_q, state_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [IdxWidth-1:0]    grant_q, grant_d;
  logic [WeightWidth-1:0] quota_q, quota_d;

  logic                   sel_found;
  logic [IdxWidth-1:0]    sel_idx;
  logic [WeightWidth-1:0] weight_arr [NumReq];
  logic [WeightWidth-1:0] sel_weight;
  logic [WeightWidth-1:0] sel_quota;

  rr_select #(
    .NumReq (NumReq)
  ) u_rr_select (
    .req_i   (valid_i),
    .ptr_i   (ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] v);
    return (v == IdxWidth'(NumReq - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      weight_arr[k] = weight_i[k*WeightWidth +: WeightWidth];
    end
  end

  // A zero weight still grants one beat.
  assign sel_weight = weight_arr[sel_idx];
  assign sel_quota  = (sel_weight == '0) ? WeightWidth'(1) : sel_weight;

  // Next-state and forwarding. Flush overrides everything except reset;
  // reset also masks the combinational forwarding so valid/ready drop
  // the moment rst_i rises.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    quota_d = quota_q;
    grant_d = grant_q;
    valid_o = 1'b0;
    ready_o = '0;
    idx_o   = grant_q;

    if (state_q == FLUSH) begin
      ptr_d   = '0;
      quota_d = '0;
      state_d = IDLE;
    end

    if (flush_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            valid_o          = 1'b1;
            idx_o            = sel_idx;
            ready_o[sel_idx] = ready_i;
            grant_d          = sel_idx;
            if (ready_i) begin
              if (sel_quota == WeightWidth'(1)) begin
                ptr_d = wrap_inc(sel_idx);
              end else begin
                state_d = SERVE;
                quota_d = sel_quota - 1'b1;
              end
            end else begin
              // Lock the grant so a stalled beat cannot switch source.
              state_d = SERVE;
              quota_d = sel_quota;
            end
          end
        end
        SERVE: begin
          valid_o          = valid_i[grant_q];
          ready_o[grant_q] = ready_i;
          if (!valid_i[grant_q]) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(grant_q);
          end else if (ready_i) begin
            if (quota_q <= WeightWidth'(1)) begin
              state_d = IDLE;
              ptr_d   = wrap_inc(grant_q);
              quota_d = '0;
            end else begin
              quota_d = quota_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (rst_i) begin
      valid_o = 1'b0;
      ready_o = '0;
      idx_o   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      quota_q <= quota_d;
    end
  end

  assign data_o  = data_i[idx_o];
  assign flush_o = (state_q == FLUSH);
  assign busy_o  = (state_q != IDLE);

endmodule
